// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_arbiter
//  Description : Two-port front end for one shared combinational ALU.
//                Grants one requester per cycle (round-robin or fixed
//                priority), routes its operands to the ALU and captures the
//                result and flags in a per-port response register.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,

  input  logic        r0_valid,
  output logic        r0_ready,
  input  logic [31:0] r0_a,
  input  logic [31:0] r0_b,
  input  logic [2:0]  r0_alu_ctrl,
  input  logic [1:0]  r0_slt_ctrl,
  output logic        r0_rsp_valid,
  input  logic        r0_rsp_ready,
  output logic [31:0] r0_result,
  output logic [3:0]  r0_flags,

  input  logic        r1_valid,
  output logic        r1_ready,
  input  logic [31:0] r1_a,
  input  logic [31:0] r1_b,
  input  logic [2:0]  r1_alu_ctrl,
  input  logic [1:0]  r1_slt_ctrl,
  output logic        r1_rsp_valid,
  input  logic        r1_rsp_ready,
  output logic [31:0] r1_result,
  output logic [3:0]  r1_flags,

  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  output logic [1:0]  alu_slt,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,

  output logic [15:0] op_count
);

  logic elig0;
  logic elig1;
  logic tie_pick0;
  logic grant0;
  logic grant1;
  logic last_grant;

  // A port may issue only if its response slot is empty or drains this cycle.
  // Reset blocks every grant so nothing is accepted while RST is high.
  assign elig0 = ~RST & r0_valid & (~r0_rsp_valid | r0_rsp_ready);
  assign elig1 = ~RST & r1_valid & (~r1_rsp_valid | r1_rsp_ready);

  // Tie-break: port 0 always wins in fixed mode; in round-robin mode port 0
  // wins only when port 1 was the last one served.
  generate
    if (FIXED_PRIO) begin : g_fixed_prio
      assign tie_pick0 = 1'b1;
    end else begin : g_round_robin
      assign tie_pick0 = last_grant;
    end
  endgenerate

  // One-hot (or empty) grant vector derived from eligibility and tie-break.
  always_comb begin
    grant0 = elig0 & (~elig1 | tie_pick0);
    grant1 = elig1 & ~grant0;
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  // Steer the granted port's operands onto the shared ALU; idle bus is zero.
  always_comb begin
    alu_a    = 32'd0;
    alu_b    = 32'd0;
    alu_ctrl = 3'b000;
    alu_slt  = 2'b00;
    if (grant0) begin
      alu_a    = r0_a;
      alu_b    = r0_b;
      alu_ctrl = r0_alu_ctrl;
      alu_slt  = r0_slt_ctrl;
    end else if (grant1) begin
      alu_a    = r1_a;
      alu_b    = r1_b;
      alu_ctrl = r1_alu_ctrl;
      alu_slt  = r1_slt_ctrl;
    end
  end

  // Port 0 response slot: load on grant, hold while unconsumed, clear on drain.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r0_rsp_valid <= 1'b0;
      r0_result    <= 32'd0;
      r0_flags     <= 4'd0;
    end else if (grant0) begin
      r0_rsp_valid <= 1'b1;
      r0_result    <= alu_result;
      r0_flags     <= alu_flags;
    end else if (r0_rsp_ready) begin
      r0_rsp_valid <= 1'b0;
    end
  end

  // Port 1 response slot: same behaviour as port 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r1_rsp_valid <= 1'b0;
      r1_result    <= 32'd0;
      r1_flags     <= 4'd0;
    end else if (grant1) begin
      r1_rsp_valid <= 1'b1;
      r1_result    <= alu_result;
      r1_flags     <= alu_flags;
    end else if (r1_rsp_ready) begin
      r1_rsp_valid <= 1'b0;
    end
  end

  // Remember the last served port and count accepted operations (wrapping).
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_grant <= 1'b1;
      op_count   <= 16'd0;
    end else if (grant0 | grant1) begin
      last_grant <= grant1;
      op_count   <= op_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_arbiter
//  Description : Self-checking bench for alu_arbiter with a stand-in ALU and
//                a transaction-level reference model of the arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic CLK = 1'b0;
  logic rst;
  logic [1:0]        v, rr;
  logic [1:0][31:0]  a, b;
  logic [1:0][2:0]   ctl;
  logic [1:0][1:0]   slt;

  logic [1:0]        rdy, rsp_v, f_rdy, f_rsp_v;
  logic [1:0][31:0]  res, f_res;
  logic [1:0][3:0]   flg, f_flg;
  logic [31:0] alu_a, alu_b, alu_result, f_alu_a, f_alu_b, f_alu_result;
  logic [2:0]  alu_ctrl, f_alu_ctrl;
  logic [1:0]  alu_slt, f_alu_slt;
  logic [3:0]  alu_flags, f_alu_flags;
  logic [15:0] op_count, f_op_count;

  int n_cmp = 0;
  int n_err = 0;

  // reference model state
  logic [1:0]       m_v;
  logic [1:0][31:0] m_res;
  logic [1:0][3:0]  m_flg;
  logic [15:0]      m_cnt;
  logic             m_last;
  logic [1:0]       seen_rdy, seen_frdy;

  always #5 CLK = ~CLK;

  // Behavioural ALU: returns {flags Z,C,V,N, result}
  function automatic logic [35:0] alu_ref(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] op, input logic [1:0] s);
    logic [32:0] sum;
    logic [31:0] r;
    logic c, o;
    c = 1'b0; o = 1'b0; sum = 33'd0;
    case (op)
      3'd0: begin sum = {1'b0, x} + {1'b0, y}; r = sum[31:0]; c = sum[32];
                  o = (x[31] == y[31]) && (r[31] != x[31]); end
      3'd1: begin r = x - y; c = (x < y); o = (x[31] != y[31]) && (r[31] != x[31]); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: r = x << y[4:0];
      3'd6: r = $signed(x) >>> y[4:0];
      default: r = x >> y[4:0];
    endcase
    if (s == 2'b01) r = {31'd0, ($signed(x) < $signed(y))};
    else if (s == 2'b10) r = {31'd0, (x < y)};
    return {(r == 32'd0), c, o, r[31], r};
  endfunction

  assign {alu_flags, alu_result}     = alu_ref(alu_a, alu_b, alu_ctrl, alu_slt);
  assign {f_alu_flags, f_alu_result} = alu_ref(f_alu_a, f_alu_b, f_alu_ctrl, f_alu_slt);

  alu_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .CLK(CLK), .RST(rst),
    .r0_valid(v[0]), .r0_ready(rdy[0]), .r0_a(a[0]), .r0_b(b[0]),
    .r0_alu_ctrl(ctl[0]), .r0_slt_ctrl(slt[0]), .r0_rsp_valid(rsp_v[0]),
    .r0_rsp_ready(rr[0]), .r0_result(res[0]), .r0_flags(flg[0]),
    .r1_valid(v[1]), .r1_ready(rdy[1]), .r1_a(a[1]), .r1_b(b[1]),
    .r1_alu_ctrl(ctl[1]), .r1_slt_ctrl(slt[1]), .r1_rsp_valid(rsp_v[1]),
    .r1_rsp_ready(rr[1]), .r1_result(res[1]), .r1_flags(flg[1]),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_slt(alu_slt),
    .alu_result(alu_result), .alu_flags(alu_flags), .op_count(op_count)
  );

  alu_arbiter #(.FIXED_PRIO(1'b1)) dut_fix (
    .CLK(CLK), .RST(rst),
    .r0_valid(v[0]), .r0_ready(f_rdy[0]), .r0_a(a[0]), .r0_b(b[0]),
    .r0_alu_ctrl(ctl[0]), .r0_slt_ctrl(slt[0]), .r0_rsp_valid(f_rsp_v[0]),
    .r0_rsp_ready(rr[0]), .r0_result(f_res[0]), .r0_flags(f_flg[0]),
    .r1_valid(v[1]), .r1_ready(f_rdy[1]), .r1_a(a[1]), .r1_b(b[1]),
    .r1_alu_ctrl(ctl[1]), .r1_slt_ctrl(slt[1]), .r1_rsp_valid(f_rsp_v[1]),
    .r1_rsp_ready(rr[1]), .r1_result(f_res[1]), .r1_flags(f_flg[1]),
    .alu_a(f_alu_a), .alu_b(f_alu_b), .alu_ctrl(f_alu_ctrl), .alu_slt(f_alu_slt),
    .alu_result(f_alu_result), .alu_flags(f_alu_flags), .op_count(f_op_count)
  );

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock: check grant/bus mid-cycle, then advance model and check registers.
  task automatic tick();
    logic [1:0] eg, g;
    logic [71:0] bus;
    logic [35:0] o;
    @(negedge CLK); #1;
    for (int n = 0; n < 2; n++) eg[n] = !rst && v[n] && (!m_v[n] || rr[n]);
    if (eg == 2'b11) g = m_last ? 2'b01 : 2'b10;
    else             g = eg;
    bus = 72'd0;
    for (int n = 0; n < 2; n++)
      if (g[n]) bus = {3'd0, a[n], b[n], ctl[n], slt[n]};
    check("ready", {70'd0, rdy}, {70'd0, g});
    check("alu_bus", {3'd0, alu_a, alu_b, alu_ctrl, alu_slt}, bus);
    seen_rdy  = rdy;
    seen_frdy = f_rdy;
    @(posedge CLK); #1;
    if (rst) begin
      m_v = 2'b00; m_res = '0; m_flg = '0; m_cnt = 16'd0; m_last = 1'b1;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (g[n]) begin
          o = alu_ref(a[n], b[n], ctl[n], slt[n]);
          m_v[n] = 1'b1; m_res[n] = o[31:0]; m_flg[n] = o[35:32];
        end else if (rr[n]) m_v[n] = 1'b0;
      end
      if (g != 2'b00) begin m_cnt = m_cnt + 16'd1; m_last = g[1]; end
    end
    check("rsp_valid", {70'd0, rsp_v}, {70'd0, m_v});
    check("result0", {40'd0, res[0]}, {40'd0, m_res[0]});
    check("result1", {40'd0, res[1]}, {40'd0, m_res[1]});
    check("flags", {64'd0, flg}, {64'd0, m_flg});
    check("op_count", {56'd0, op_count}, {56'd0, m_cnt});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m_v = 2'b00; m_res = '0; m_flg = '0; m_cnt = 16'd0; m_last = 1'b1;
    rst = 1'b1; v = 2'b11; rr = 2'b00; a = '0; b = '0; ctl = '0; slt = '0;

    // reset: nothing granted, state cleared
    tick(); tick();
    check("rst_no_ready", {70'd0, seen_rdy}, 72'd0);
    check("rst_count", {56'd0, op_count}, 72'd0);
    rst = 1'b0; v = 2'b00;

    // r0 ADD 5+7
    v = 2'b01; a[0] = 32'd5; b[0] = 32'd7; ctl[0] = 3'd0; slt[0] = 2'b00;
    tick();
    check("add_ready", {70'd0, seen_rdy}, 72'b01);
    check("add_result", {40'd0, res[0]}, 72'd12);
    check("add_flags", {68'd0, flg[0]}, 72'b0000);
    check("add_count", {56'd0, op_count}, 72'd1);

    // r1 SUB 3-3 -> zero flag
    v = 2'b10; rr = 2'b11; a[1] = 32'd3; b[1] = 32'd3; ctl[1] = 3'd1; slt[1] = 2'b00;
    tick();
    check("sub_result", {40'd0, res[1]}, 72'd0);
    check("sub_flags", {68'd0, flg[1]}, 72'b1000);

    // r0 SLT -1 < 1
    v = 2'b01; a[0] = 32'hFFFF_FFFF; b[0] = 32'd1; ctl[0] = 3'd1; slt[0] = 2'b01;
    tick();
    check("slt_result", {40'd0, res[0]}, 72'd1);

    // r0 response blocked, r1 still served, then r0 taken when drained
    v = 2'b11; rr = 2'b10; a[0] = 32'd9; b[0] = 32'd9; ctl[0] = 3'd0; slt[0] = 2'b00;
    tick();
    check("blk_ready", {70'd0, seen_rdy}, 72'b10);
    check("blk_hold", {40'd0, res[0]}, 72'd1);
    v = 2'b01; rr = 2'b11;
    tick();
    check("drain_ready", {70'd0, seen_rdy}, 72'b01);
    check("drain_result", {40'd0, res[0]}, 72'd18);

    // reset right after an acceptance discards the response
    tick();
    rst = 1'b1; v = 2'b00;
    tick();
    rst = 1'b0;
    check("rst_rsp_valid", {71'd0, rsp_v[0]}, 72'd0);
    check("rst_op_count", {56'd0, op_count}, 72'd0);
    tick();
    check("post_rst_rsp", {71'd0, rsp_v[0]}, 72'd0);

    // contention: round-robin alternates from port 0, fixed always port 0
    v = 2'b11; rr = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_order", {70'd0, seen_rdy}, (k % 2 == 0) ? 72'b01 : 72'b10);
      check("fixed_order", {70'd0, seen_frdy}, 72'b01);
    end

    // op_count wrap
    rst = 1'b1; tick(); rst = 1'b0;
    v = 2'b11; rr = 2'b11;
    repeat (65535) @(posedge CLK);
    #1;
    check("count_max", {56'd0, op_count}, 72'hFFFF);
    @(posedge CLK); #1;
    check("count_wrap", {56'd0, op_count}, 72'h0);
    rst = 1'b1; tick(); rst = 1'b0;

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 49) == 0);
      v   = 2'($urandom_range(0, 3));
      rr  = 2'($urandom_range(0, 3));
      for (int n = 0; n < 2; n++) begin
        a[n]   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
        b[n]   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        ctl[n] = 3'($urandom_range(0, 7));
        slt[n] = 2'($urandom_range(0, 3));
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0: 0 selects round-robin arbitration, 1 selects fixed priority with port 0 highest.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have ports rN_valid (N=0,1), input, 1 bit each: requester N presents an operation.
REQ-005 The block SHALL have ports rN_ready, output, 1 bit each: the block accepts requester N's operation this cycle.
REQ-006 The block SHALL have ports rN_a and rN_b, input, 32 bits each: operands.
REQ-007 The block SHALL have ports rN_alu_ctrl, input, 3 bits each: ALU op code (000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRA, 111 SRL).
REQ-008 The block SHALL have ports rN_slt_ctrl, input, 2 bits each: result select (00 normal, 01 SLT, 10 SLTU, 11 normal).
REQ-009 The block SHALL have ports rN_rsp_valid, output, 1 bit each: response register N holds a result.
REQ-010 The block SHALL have ports rN_rsp_ready, input, 1 bit each: requester N consumes its response.
REQ-011 The block SHALL have ports rN_result, output, 32 bits each, and rN_flags, output, 4 bits each: registered ALU result and flags {Z,C,V,N}.
REQ-012 The block SHALL have ports alu_a and alu_b, output, 32 bits each; alu_ctrl, output, 3 bits; and alu_slt, output, 2 bits: these drive the shared ALU.
REQ-013 The block SHALL have ports alu_result, input, 32 bits, and alu_flags, input, 4 bits: the combinational return from the shared ALU.
REQ-014 The block SHALL have port op_count, output, 16 bits: the total number of accepted operations.

Function
REQ-015 Port N SHALL be eligible when rN_valid=1 and its response slot is free: rN_rsp_valid=0, or rN_rsp_ready=1 in the same cycle.
REQ-016 Grant SHALL be combinational, with at most one port granted per cycle, and SHALL be given only to an eligible port.
REQ-017 When both ports are eligible and FIXED_PRIO=0, grant SHALL go to the port not named by the last_grant register.
REQ-018 When both ports are eligible and FIXED_PRIO=1, grant SHALL go to port 0.
REQ-019 rN_ready SHALL be 1 exactly when port N is granted, independent of whether rN_valid would drop.
REQ-020 An operation SHALL be accepted when rN_valid=1 and rN_ready=1 in the same cycle.
REQ-021 During a grant, alu_a, alu_b, alu_ctrl and alu_slt SHALL carry the granted port's inputs combinationally.
REQ-022 With no grant, alu_a and alu_b SHALL be 0, alu_ctrl SHALL be 000 and alu_slt SHALL be 00.
REQ-023 On acceptance from port N, at the next edge: rN_result SHALL load alu_result, rN_flags SHALL load alu_flags, rN_rsp_valid SHALL be set, last_grant SHALL load N, and op_count SHALL increment.
REQ-024 Latency from acceptance to rsp_valid SHALL be 1 cycle; throughput SHALL be 1 operation per cycle across both ports.
REQ-025 While rN_rsp_valid=1 and rN_rsp_ready=0, rN_result and rN_flags SHALL hold stable.
REQ-026 rN_rsp_valid SHALL clear on an edge with rN_rsp_ready=1 and no new acceptance for port N.
REQ-027 On simultaneous consume and new acceptance for port N, rN_rsp_valid SHALL stay 1 and the new result SHALL load.
REQ-028 op_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-029 A port SHALL never be starved: with FIXED_PRIO=0 and both ports continuously eligible, grants SHALL alternate 0,1,0,1,...
REQ-030 Port 1 SHALL always see alu_* driven with port 1's inputs during its grant, even when r0_valid=1 in the same cycle.

Reset
REQ-031 While RST=1 at an edge: rN_rsp_valid SHALL be 0, rN_result SHALL be 0, rN_flags SHALL be 0, op_count SHALL be 0, and last_grant SHALL be 1, so port 0 wins the first tie.
REQ-032 While RST=1, rN_ready SHALL be 0 and no operation SHALL be accepted.
REQ-033 Reset asserted with a response pending SHALL discard that response, with no rsp_valid in the cycle after deassertion.

Verification
REQ-034 Scenario: r0 ADD a=5, b=7, slt=00 -> r0_ready=1 the same cycle; the next cycle r0_rsp_valid=1, r0_result=12, r0_flags=0000, op_count=1.
REQ-035 Scenario: r1 SUB a=3, b=3 -> r1_result=0 and r1_flags=1000 one cycle later.
REQ-036 Scenario: r0 SUB a=32'hFFFFFFFF, b=1, slt=01 -> r0_result=1 (SLT true).
REQ-037 Scenario: after reset both ports valid continuously with rsp_ready=1 -> grants go 0,1,0,1; with FIXED_PRIO=1 -> port 0 every cycle.
REQ-038 Scenario: r0_rsp_ready=0 with a response pending and a second r0 request -> r0_ready=0 and r0_result held; r1 is still granted; after r0_rsp_ready=1, r0 is accepted the same cycle.
REQ-039 Scenario: RST=1 for one cycle the cycle after acceptance -> r0_rsp_valid=0, op_count=0, and the next tie is granted to port 0.
